// File: rtl/mem_access_stage_pkg.sv
// mips_mem_pkg: shared encodings for the MEM stage (access sizes, FSM states, byte-enable patterns, misalignment test)
package mips_mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;
    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;
    // Size 2'b11 is a word access, so anything that is not byte/half is checked as a word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_BYTE) ? 1'b0 : (size == SZ_HALF) ? addr_lo[0] : (addr_lo != 2'b00);
    endfunction
endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: picks the addressed byte/half lane of a read word and sign- or zero-extends it
//   rdata_i    read word from data memory
//   addr_i     low address bits selecting the lane
//   size_i     access size (byte/half/word, 11 = word)
//   unsigned_i zero-extend instead of sign-extend
//   data_o     extended load value
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata_i[8*addr_i +: 8];
        h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o = (size_i == SZ_BYTE) ? {{24{~unsigned_i & b[7]}}, b} :
                 (size_i == SZ_HALF) ? {{16{~unsigned_i & h[15]}}, h} : rdata_i;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with MEM/WB register; variable-latency data memory over req/ack
//   EX/MEM in : in_valid, alu_result_in, store_data_in, mem_read_in, mem_write_in, mem_size_in,
//               mem_unsigned_in, memtoreg_in, datac_in, pc_adder_in, reg_write_in, write_reg_in
//   stall_out : freezes the upstream pipeline while an access is outstanding
//   dmem_*    : req/ack data-memory port, request held constant until ack
//   WB out    : wb_valid pulse, alu_result, read_data_mem, MemtoReg, DataC, pc_adder, reg_write, write_reg
//   misalign_exc : exception pulse, only when MEM_MISALIGN_EXC_EN is defined; otherwise tied 0
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     store_data_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic [1:0]            mem_size_in,
    input  logic                  mem_unsigned_in,
    input  logic                  memtoreg_in,
    input  logic                  datac_in,
    input  logic [DATA_W-1:0]     pc_adder_in,
    input  logic                  reg_write_in,
    input  logic [REG_ADDR_W-1:0] write_reg_in,
    output logic                  stall_out,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     alu_result,
    output logic [DATA_W-1:0]     read_data_mem,
    output logic                  MemtoReg,
    output logic                  DataC,
    output logic [DATA_W-1:0]     pc_adder,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic                  misalign_exc
);
    state_t                state_q, state_d;
    logic [DATA_W-1:0]     addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
    logic [3:0]            be_q, be_d;
    logic [1:0]            size_q, size_d;
    logic                  we_q, we_d, uns_q, uns_d, m2r_q, m2r_d, dc_q, dc_d, rw_q, rw_d;
    logic [REG_ADDR_W-1:0] wr_q, wr_d;
    logic                  wbv_q, wbv_d, wb_m2r_q, wb_m2r_d, wb_dc_q, wb_dc_d, wb_rw_q, wb_rw_d;
    logic [DATA_W-1:0]     alu_q, alu_d, rdm_q, rdm_d, wb_pc_q, wb_pc_d;
    logic [REG_ADDR_W-1:0] wb_wr_q, wb_wr_d;
    logic                  start, mem_op, mis;
    logic [3:0]            be_in;
    logic [DATA_W-1:0]     wdata_in, ld_data;

    assign start  = (state_q == ST_IDLE) && in_valid;
    assign mem_op = mem_read_in | mem_write_in;
`ifdef MEM_MISALIGN_EXC_EN
    logic exc_q;
    assign mis          = is_misaligned(mem_size_in, alu_result_in[1:0]);
    assign misalign_exc = exc_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) exc_q <= 1'b0;
        else     exc_q <= start & mem_op & mis;
`else
    assign mis          = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    always_comb begin
        be_in    = (mem_size_in == SZ_BYTE) ? BE_BYTE << alu_result_in[1:0] :
                   (mem_size_in == SZ_HALF) ? BE_HALF << {alu_result_in[1], 1'b0} : BE_WORD;
        wdata_in = (mem_size_in == SZ_BYTE) ? {4{store_data_in[7:0]}} :
                   (mem_size_in == SZ_HALF) ? {2{store_data_in[15:0]}} : store_data_in;
    end

    load_align u_load_align (
        .rdata_i    (dmem_rdata),
        .addr_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ld_data)
    );

    // The issuing cycle stalls combinationally so EX/MEM holds while the request is latched
    assign stall_out  = (start & mem_op & ~mis) | ((state_q == ST_ACCESS) & ~dmem_ack);
    assign dmem_req   = state_q == ST_ACCESS;
    assign dmem_we    = dmem_req & we_q;
    assign dmem_be    = dmem_req ? be_q : 4'b0000;
    assign dmem_addr  = {addr_q[DATA_W-1:2], 2'b00};
    assign dmem_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        addr_d = addr_q; wdata_d = wdata_q; be_d = be_q; size_d = size_q; we_d = we_q; uns_d = uns_q;
        m2r_d = m2r_q; dc_d = dc_q; pc_d = pc_q; rw_d = rw_q; wr_d = wr_q;
        wbv_d = 1'b0; wb_rw_d = 1'b0;
        alu_d = alu_q; rdm_d = rdm_q; wb_m2r_d = wb_m2r_q; wb_dc_d = wb_dc_q; wb_pc_d = wb_pc_q; wb_wr_d = wb_wr_q;
        if (start && mem_op && !mis) begin
            state_d = ST_ACCESS;
            addr_d = alu_result_in; wdata_d = wdata_in; be_d = be_in; size_d = mem_size_in;
            we_d = mem_write_in; uns_d = mem_unsigned_in;
            m2r_d = memtoreg_in; dc_d = datac_in; pc_d = pc_adder_in; rw_d = reg_write_in; wr_d = write_reg_in;
        end else if (start) begin
            // Plain ALU op, or a misaligned access retiring straight to WB as an exception
            wbv_d = 1'b1; alu_d = alu_result_in; rdm_d = '0;
            wb_m2r_d = memtoreg_in; wb_dc_d = datac_in; wb_pc_d = pc_adder_in;
            wb_rw_d = reg_write_in & ~mem_op; wb_wr_d = write_reg_in;
        end else if (state_q == ST_ACCESS && dmem_ack) begin
            state_d = ST_IDLE;
            wbv_d = 1'b1; alu_d = addr_q; rdm_d = we_q ? '0 : ld_data;
            wb_m2r_d = m2r_q; wb_dc_d = dc_q; wb_pc_d = pc_q;
            wb_rw_d = rw_q & ~we_q; wb_wr_d = wr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q <= '0; wdata_q <= '0; be_q <= '0; size_q <= '0; we_q <= 1'b0; uns_q <= 1'b0;
            m2r_q <= 1'b0; dc_q <= 1'b0; pc_q <= '0; rw_q <= 1'b0; wr_q <= '0;
            wbv_q <= 1'b0; alu_q <= '0; rdm_q <= '0; wb_m2r_q <= 1'b0; wb_dc_q <= 1'b0;
            wb_pc_q <= '0; wb_rw_q <= 1'b0; wb_wr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d; wdata_q <= wdata_d; be_q <= be_d; size_q <= size_d; we_q <= we_d; uns_q <= uns_d;
            m2r_q <= m2r_d; dc_q <= dc_d; pc_q <= pc_d; rw_q <= rw_d; wr_q <= wr_d;
            wbv_q <= wbv_d; alu_q <= alu_d; rdm_q <= rdm_d; wb_m2r_q <= wb_m2r_d; wb_dc_q <= wb_dc_d;
            wb_pc_q <= wb_pc_d; wb_rw_q <= wb_rw_d; wb_wr_q <= wb_wr_d;
        end
    end

    assign wb_valid      = wbv_q;
    assign alu_result    = alu_q;
    assign read_data_mem = rdm_q;
    assign MemtoReg      = wb_m2r_q;
    assign DataC         = wb_dc_q;
    assign pc_adder      = wb_pc_q;
    assign reg_write     = wb_rw_q;
    assign write_reg     = wb_wr_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed + randomized checks of mem_access_stage against a lane/extension model
module tb_mem_access_stage;
`ifdef MEM_MISALIGN_EXC_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0, mem_unsigned_in = 1'b0;
    logic memtoreg_in = 1'b0, datac_in = 1'b0, reg_write_in = 1'b0, dmem_ack = 1'b0;
    logic [31:0] alu_result_in = '0, store_data_in = '0, pc_adder_in = '0, dmem_rdata = '0;
    logic [1:0] mem_size_in = '0;
    logic [4:0] write_reg_in = '0;
    logic stall_out, dmem_req, dmem_we, wb_valid, MemtoReg, DataC, reg_write, misalign_exc;
    logic [31:0] dmem_addr, dmem_wdata, alu_result, read_data_mem, pc_adder;
    logic [3:0] dmem_be;
    logic [4:0] write_reg;
    int tests = 0, fails = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in), .memtoreg_in(memtoreg_in),
        .datac_in(datac_in), .pc_adder_in(pc_adder_in), .reg_write_in(reg_write_in),
        .write_reg_in(write_reg_in), .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .alu_result(alu_result),
        .read_data_mem(read_data_mem), .MemtoReg(MemtoReg), .DataC(DataC), .pc_adder(pc_adder),
        .reg_write(reg_write), .write_reg(write_reg), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // First byte lane touched: the access is aligned down to its own size
    function automatic int first_lane(input logic [31:0] a, input logic [1:0] sz);
        return (int'(a % 4) / nbytes(sz)) * nbytes(sz);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
        int n = nbytes(sz);
        longint v = longint'(rdata >> (8 * first_lane(a, sz))) & ((longint'(1) << (8 * n)) - 1);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] sz);
        logic [3:0] be = '0;
        for (int k = 0; k < 4; k++) be[k] = (k >= first_lane(a, sz)) && (k < first_lane(a, sz) + nbytes(sz));
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % nbytes(sz)) +: 8];
        return w;
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [1:0] sz);
        return FEAT && ((sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00));
    endfunction

    // Issues one instruction at a negedge and follows it to write-back
    task automatic op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                      input logic m2r, input logic dc, input logic [31:0] pc, input logic rw,
                      input logic [4:0] wrg, input logic [31:0] rdata, input int waits);
        bit memop = rd | wr;
        bit mis = memop && misaligned(addr, sz);
        bit access = memop && !mis;
        int stalls = 0;
        in_valid = 1'b1; mem_read_in = rd; mem_write_in = wr; mem_size_in = sz; mem_unsigned_in = uns;
        alu_result_in = addr; store_data_in = sdata; memtoreg_in = m2r; datac_in = dc;
        pc_adder_in = pc; reg_write_in = rw; write_reg_in = wrg;
        #1;
        chk({tag, ":stall_issue"}, 32'(stall_out), 32'(access));
        if (stall_out) stalls++;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; alu_result_in = $urandom; store_data_in = $urandom; write_reg_in = 5'($urandom);
        if (access) begin
            chk({tag, ":req"}, 32'(dmem_req), 32'd1);
            chk({tag, ":we"}, 32'(dmem_we), 32'(wr));
            chk({tag, ":addr"}, dmem_addr, addr & ~32'd3);
            chk({tag, ":be"}, 32'(dmem_be), 32'(exp_be(addr, sz)));
            if (wr) chk({tag, ":wdata"}, dmem_wdata, exp_wdata(sdata, sz));
            for (int i = 0; i < waits; i++) begin
                if (stall_out) stalls++;
                @(posedge clk); @(negedge clk);
                chk({tag, ":addr_hold"}, dmem_addr, addr & ~32'd3);
            end
            dmem_ack = 1'b1; dmem_rdata = rdata;
            #1;
            chk({tag, ":stall_ack"}, 32'(stall_out), 32'd0);
            @(posedge clk); @(negedge clk);
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            chk({tag, ":stall_cycles"}, 32'(stalls), 32'(waits + 1));
        end else if (memop) chk({tag, ":no_req"}, 32'(dmem_req), 32'd0);
        chk({tag, ":wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, ":alu_result"}, alu_result, addr);
        if (access) chk({tag, ":rdata"}, read_data_mem, wr ? 32'd0 : exp_load(rdata, addr, sz, uns));
        chk({tag, ":ctl"}, {29'd0, MemtoReg, DataC, misalign_exc}, {29'd0, m2r, dc, mis});
        chk({tag, ":pc_adder"}, pc_adder, pc);
        chk({tag, ":reg_write"}, 32'(reg_write), 32'(rw && !wr && !mis));
        chk({tag, ":write_reg"}, 32'(write_reg), 32'(wrg));
        @(negedge clk);
        chk({tag, ":wb_drop"}, {29'd0, wb_valid, reg_write, misalign_exc}, 32'd0);
        chk({tag, ":alu_hold"}, alu_result, addr);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_wb", {28'd0, wb_valid, reg_write, dmem_req, stall_out}, 32'd0);
        chk("reset_alu", alu_result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        op("alu", 0, 0, 2'd2, 0, 32'h1234, 0, 0, 0, 32'h0, 1, 5'd5, 0, 0);
        op("lb", 1, 0, 2'd0, 0, 32'h1003, 0, 1, 0, 32'h0, 1, 5'd8, 32'h80FF_0000, 3);
        chk("lb_value", read_data_mem, 32'hFFFF_FF80);
        op("lbu", 1, 0, 2'd0, 1, 32'h1003, 0, 1, 0, 32'h0, 1, 5'd9, 32'h80FF_0000, 1);
        chk("lbu_value", read_data_mem, 32'h0000_0080);
        op("sh", 0, 1, 2'd1, 0, 32'h2002, 32'h0000_ABCD, 0, 0, 32'h0, 1, 5'd3, 0, 0);
        op("jal", 0, 0, 2'd2, 0, 32'h0, 0, 0, 1, 32'h0040_0008, 1, 5'd31, 0, 0);
        chk("jal_pc", pc_adder, 32'h0040_0008);
        op("lw_mis", 1, 0, 2'd2, 0, 32'h3001, 0, 1, 0, 32'h0, 1, 5'd4, 32'hCAFE_F00D, 2);
        op("rd_wr", 1, 1, 2'd2, 0, 32'h4000, 32'h1111_2222, 1, 0, 32'h0, 1, 5'd6, 32'h5555_6666, 1);
        op("lh_sz3", 1, 0, 2'd3, 0, 32'h4004, 0, 1, 0, 32'h0, 1, 5'd7, 32'h8765_4321, 0);
        for (int i = 0; i < 40; i++) begin
            logic [1:0] rdwr = 2'($urandom_range(0, 3));
            op("rand", rdwr[0], rdwr[1], 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
               1'($urandom), 1'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom,
               $urandom_range(0, 3));
        end
        in_valid = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b1; mem_size_in = 2'd2;
        alu_result_in = 32'h5000; reg_write_in = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("rst_pre_req", {30'd0, dmem_req, dmem_we}, 32'd3);
        rst = 1'b1;
        #1;
        chk("rst_req_drop", {27'd0, dmem_req, dmem_we, stall_out, wb_valid, reg_write}, 32'd0);
        chk("rst_be_drop", 32'(dmem_be), 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        chk("late_ack_stall", 32'(stall_out), 32'd0);
        @(posedge clk); @(negedge clk);
        dmem_ack = 1'b0;
        chk("late_ack_wb", {30'd0, wb_valid, dmem_req}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
